// File: rtl/fp_pkg.sv
// Shared constants and tag encodings for the floating-point add/subtract unit.
package fp_pkg;

  // Default format: binary16
  localparam int unsigned EXP_W_DEF = 5;
  localparam int unsigned MAN_W_DEF = 10;
  localparam int unsigned BIAS      = (1 << (EXP_W_DEF - 1)) - 1;
  localparam int unsigned EXP_MAX   = (1 << EXP_W_DEF) - 1;

  // Canonical quiet NaN for the default format
  localparam logic [EXP_W_DEF+MAN_W_DEF:0] QNAN_DEF =
    {1'b0, {EXP_W_DEF{1'b1}}, 1'b1, {(MAN_W_DEF-1){1'b0}}};

  // Bit positions inside the {invalid, overflow, inexact} flag word
  localparam int unsigned FLAG_W        = 3;
  localparam int unsigned FLAG_INEXACT  = 0;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_INVALID  = 2;

  // Special-value class carried down the pipeline alongside the datapath
  typedef enum logic [1:0] {
    TAG_NORM = 2'd0,
    TAG_ZERO = 2'd1,
    TAG_INF  = 2'd2,
    TAG_QNAN = 2'd3
  } fp_tag_e;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input yields W.
module fp_lzc #(
  parameter int unsigned W = 14
) (
  input  logic [W-1:0]             d,
  output logic [$clog2(W+1)-1:0]   cnt
);

  localparam int unsigned CW = $clog2(W + 1);

  // Scan upward so the highest set bit decides the count
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < int'(W); i++) begin
      if (d[i]) cnt = CW'(int'(W) - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with RNE rounding,
// flush-to-zero, special-value handling and a valid/ready handshake.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   o,
  output logic [FLAG_W-1:0]      flags
);

  localparam int unsigned W      = 1 + EXP_W + MAN_W;
  localparam int unsigned SW     = MAN_W + 4;        // hidden + frac + G,R,S
  localparam int unsigned LZW    = $clog2(SW + 1);
  localparam int unsigned EW     = EXP_W + 2;        // signed working exponent
  localparam int unsigned SH_MAX = SW - 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------- S1: unpack / classify / align ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  assign sa = a[W-1];
  assign ea = a[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign sb = b[W-1] ^ op;
  assign eb = b[W-2:MAN_W];
  assign fb = b[MAN_W-1:0];

  logic             swap, big_s;
  logic [EXP_W-1:0] big_e, small_e, diff;
  logic [MAN_W-1:0] fa_z, fb_z, big_f, small_f;
  logic [SW-1:0]    big_sig, small_sig, small_sh, lost_mask;

  // Flush subnormals, order by magnitude and align the smaller significand
  always_comb begin
    fa_z      = (ea == '0) ? '0 : fa;
    fb_z      = (eb == '0) ? '0 : fb;
    swap      = {eb, fb_z} > {ea, fa_z};
    big_s     = swap ? sb : sa;
    big_e     = swap ? eb : ea;
    big_f     = swap ? fb_z : fa_z;
    small_e   = swap ? ea : eb;
    small_f   = swap ? fa_z : fb_z;
    big_sig   = {big_e != '0, big_f, 3'b000};
    small_sig = {small_e != '0, small_f, 3'b000};
    diff      = big_e - small_e;
    lost_mask = '0;
    small_sh  = '0;
    if (diff >= EXP_W'(SH_MAX)) begin
      small_sh = {{(SW-1){1'b0}}, |small_sig};
    end else begin
      lost_mask   = ~({SW{1'b1}} << diff);
      small_sh    = small_sig >> diff;
      small_sh[0] = small_sh[0] | (|(small_sig & lost_mask));
    end
  end

  logic    a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, inf_inf;
  fp_tag_e tag1;
  logic    inv1, sign1;

  // Classify special operands; the resulting tag overrides the datapath later
  always_comb begin
    a_nan   = (ea == EXP_ONES) && (fa != '0);
    b_nan   = (eb == EXP_ONES) && (fb != '0);
    a_inf   = (ea == EXP_ONES) && (fa == '0);
    b_inf   = (eb == EXP_ONES) && (fb == '0);
    a_snan  = a_nan && !fa[MAN_W-1];
    b_snan  = b_nan && !fb[MAN_W-1];
    inf_inf = a_inf && b_inf && (sa != sb);
    tag1    = TAG_NORM;
    inv1    = 1'b0;
    sign1   = big_s;
    if (a_nan || b_nan || inf_inf) begin
      tag1 = TAG_QNAN;
      inv1 = a_snan | b_snan | inf_inf;
    end else if (a_inf || b_inf) begin
      tag1  = TAG_INF;
      sign1 = a_inf ? sa : sb;
    end else if ((ea == '0) && (eb == '0)) begin
      tag1  = TAG_ZERO;
      sign1 = sa & sb;
    end
  end

  logic             s1_valid, s1_inv, s1_sign, s1_sub;
  fp_tag_e          s1_tag;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0]    s1_big, s1_small;

  // S1 pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= TAG_NORM;
      s1_inv   <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_exp   <= '0;
      s1_big   <= '0;
      s1_small <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_tag   <= tag1;
      s1_inv   <= inv1;
      s1_sign  <= sign1;
      s1_sub   <= sa ^ sb;
      s1_exp   <= big_e;
      s1_big   <= big_sig;
      s1_small <= small_sh;
    end
  end

  // ---------------- S2: add / normalise ----------------
  logic [SW:0]    sum;
  logic [LZW-1:0] lz;
  logic [SW-1:0]  mant2;
  logic [EW-1:0]  exp_ext, exp2;
  fp_tag_e        tag2;
  logic           sign2;

  fp_lzc #(.W(SW)) u_lzc (
    .d   (sum[SW-1:0]),
    .cnt (lz)
  );

  // Magnitude add/subtract, then renormalise; a zero hidden bit means exact zero
  always_comb begin
    sum     = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                     : ({1'b0, s1_big} + {1'b0, s1_small});
    exp_ext = {2'b00, s1_exp};
    if (sum[SW]) begin
      mant2 = {sum[SW:2], sum[1] | sum[0]};
      exp2  = exp_ext + EW'(1);
    end else begin
      mant2 = sum[SW-1:0] << lz;
      exp2  = exp_ext - EW'(lz);
    end
    tag2  = s1_tag;
    sign2 = s1_sign;
    if ((s1_tag == TAG_NORM) && !mant2[SW-1]) begin
      tag2  = TAG_ZERO;
      sign2 = 1'b0;
    end
  end

  logic          s2_valid, s2_inv, s2_sign;
  fp_tag_e       s2_tag;
  logic [EW-1:0] s2_exp;
  logic [SW-2:0] s2_mant;

  // S2 pipeline register; the hidden bit is implied from here on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_tag   <= TAG_NORM;
      s2_inv   <= 1'b0;
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_mant  <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_tag   <= tag2;
      s2_inv   <= s1_inv;
      s2_sign  <= sign2;
      s2_exp   <= exp2;
      s2_mant  <= mant2[SW-2:0];
    end
  end

  // ---------------- S3: round / pack ----------------
  logic             g_bit, r_bit, s_bit, lsb, rnd;
  logic [MAN_W:0]   frac_r;
  logic [EW-1:0]    exp3;
  logic [W-1:0]     res;
  logic [FLAG_W-1:0] res_f;

  // Round to nearest even, range-check the exponent, then apply special overrides
  always_comb begin
    g_bit  = s2_mant[2];
    r_bit  = s2_mant[1];
    s_bit  = s2_mant[0];
    lsb    = s2_mant[3];
    rnd    = g_bit & (r_bit | s_bit | lsb);
    frac_r = {1'b0, s2_mant[SW-2:3]} + (MAN_W+1)'(rnd);
    exp3   = s2_exp + EW'(frac_r[MAN_W]);
    res    = {s2_sign, exp3[EXP_W-1:0], frac_r[MAN_W-1:0]};
    res_f  = '0;
    res_f[FLAG_INEXACT] = g_bit | r_bit | s_bit;
    if (exp3[EW-1] || (exp3 == '0)) begin
      res = {s2_sign, {(W-1){1'b0}}};
      res_f[FLAG_INEXACT] = 1'b1;
    end else if (exp3 >= EW'(EXP_ONES)) begin
      res = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      res_f[FLAG_OVERFLOW] = 1'b1;
      res_f[FLAG_INEXACT]  = 1'b1;
    end
    case (s2_tag)
      TAG_QNAN: begin
        res   = QNAN;
        res_f = '0;
        res_f[FLAG_INVALID] = s2_inv;
      end
      TAG_INF: begin
        res   = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
        res_f = '0;
      end
      TAG_ZERO: begin
        res   = {s2_sign, {(W-1){1'b0}}};
        res_f = '0;
      end
      default: ;
    endcase
  end

  // Output register; holds while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      o         <= '0;
      flags     <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        o     <= res;
        flags <= res_f;
      end
    end
  end

endmodule
